// File: rtl/stopwatch_ctrl_if.sv
// Button, timer and display signals shared between the debounce wrapper,
// the countdown timer, the display driver and the stopwatch mode controller.
interface stopwatch_ctrl_if;
  logic       clk1k;
  logic       start;
  logic       stop;
  logic       softrst;
  logic       mode_btn;
  logic       lap_btn;
  logic [5:0] timer_minutes;
  logic [5:0] timer_seconds;
  logic       timer_blink;
  logic       timer_start;
  logic       timer_stop;
  logic       timer_reset;
  logic       timer_inc_en;
  logic       mode;
  logic [5:0] disp_minutes;
  logic [5:0] disp_seconds;
  logic       blink;

  modport master (
    output clk1k, start, stop, softrst, mode_btn, lap_btn,
    output timer_minutes, timer_seconds, timer_blink,
    input  timer_start, timer_stop, timer_reset, timer_inc_en, mode,
    input  disp_minutes, disp_seconds, blink
  );

  modport slave (
    input  clk1k, start, stop, softrst, mode_btn, lap_btn,
    input  timer_minutes, timer_seconds, timer_blink,
    output timer_start, timer_stop, timer_reset, timer_inc_en, mode,
    output disp_minutes, disp_seconds, blink
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Timer/stopwatch mode controller: routes the shared buttons, runs the MM:SS
// stopwatch with lap and overflow handling, and muxes the display driver.
module stopwatch_ctrl #(
  parameter int MS_PER_SEC = 1000,
  parameter int MAX_MIN    = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);
  localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE, S_OVF} sw_state_e;

  sw_state_e       state_q, state_d;
  logic [4:0]      btn_q;
  logic [2:0]      k_sync_q;
  logic            mode_q, mode_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic [5:0]      sec_q, sec_d, min_q, min_d;
  logic [5:0]      lap_sec_q, lap_sec_d, lap_min_q, lap_min_d;
  logic            t_start_q, t_stop_q, t_reset_q;
  logic [5:0]      disp_min_q, disp_min_d, disp_sec_q, disp_sec_d;
  logic            blink_q, blink_d;

  logic ev_start, ev_stop, ev_soft, ev_mode, ev_lap, tick;
  logic sw_start, sw_stop, sw_soft, sw_lap, counting, at_max;

  assign ev_start = bus.start    & ~btn_q[0];
  assign ev_stop  = bus.stop     & ~btn_q[1];
  assign ev_soft  = bus.softrst  & ~btn_q[2];
  assign ev_mode  = bus.mode_btn & ~btn_q[3];
  assign ev_lap   = bus.lap_btn  & ~btn_q[4];
  assign tick     = k_sync_q[1] & ~k_sync_q[2];

  // Events are routed by the mode in force before any same-cycle toggle.
  assign sw_start = mode_q & ev_start;
  assign sw_stop  = mode_q & ev_stop;
  assign sw_soft  = mode_q & ev_soft;
  assign sw_lap   = mode_q & ev_lap;

  assign counting = ((state_q == S_RUN) || (state_q == S_LAP)) && tick;
  assign at_max   = (min_q == 6'(MAX_MIN)) && (sec_q == 6'd59) &&
                    (ms_q == MS_W'(MS_PER_SEC - 1));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q ^ ev_mode;
    ms_d      = ms_q;
    sec_d     = sec_q;
    min_d     = min_q;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    if (sw_soft) begin
      state_d   = S_IDLE;
      ms_d      = '0;
      sec_d     = '0;
      min_d     = '0;
      lap_sec_d = '0;
      lap_min_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE:  if (sw_start) state_d = S_RUN;
        S_RUN: begin
          if (sw_stop) state_d = S_PAUSE;
          else if (sw_lap) begin
            state_d   = S_LAP;
            lap_sec_d = sec_q;
            lap_min_d = min_q;
          end
        end
        S_LAP: begin
          if (sw_stop)     state_d = S_PAUSE;
          else if (sw_lap) state_d = S_RUN;
        end
        S_PAUSE: if (sw_start) state_d = S_RUN;
        default: state_d = state_q;
      endcase
      // A tick alongside stop is still counted; saturation wins over any transition.
      if (counting) begin
        if (at_max) begin
          state_d = S_OVF;
        end else if (ms_q == MS_W'(MS_PER_SEC - 1)) begin
          ms_d = '0;
          if (sec_q == 6'd59) begin
            sec_d = '0;
            min_d = min_q + 6'd1;
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          ms_d = ms_q + MS_W'(1);
        end
      end
    end
  end

  always_comb begin
    if (!mode_q) begin
      disp_min_d = bus.timer_minutes;
      disp_sec_d = bus.timer_seconds;
      blink_d    = bus.timer_blink;
    end else if (state_q == S_LAP) begin
      disp_min_d = lap_min_q;
      disp_sec_d = lap_sec_q;
      blink_d    = 1'b0;
    end else begin
      disp_min_d = min_q;
      disp_sec_d = sec_q;
      blink_d    = (state_q == S_PAUSE) || (state_q == S_OVF);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      btn_q      <= '0;
      k_sync_q   <= '0;
      mode_q     <= 1'b0;
      ms_q       <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      t_start_q  <= 1'b0;
      t_stop_q   <= 1'b0;
      t_reset_q  <= 1'b0;
      disp_min_q <= '0;
      disp_sec_q <= '0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= {bus.lap_btn, bus.mode_btn, bus.softrst, bus.stop, bus.start};
      k_sync_q   <= {k_sync_q[1:0], bus.clk1k};
      mode_q     <= mode_d;
      ms_q       <= ms_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      t_start_q  <= ~mode_q & ev_start;
      t_stop_q   <= ~mode_q & ev_stop;
      t_reset_q  <= ~mode_q & ev_soft;
      disp_min_q <= disp_min_d;
      disp_sec_q <= disp_sec_d;
      blink_q    <= blink_d;
    end
  end

  assign bus.timer_start  = t_start_q;
  assign bus.timer_stop   = t_stop_q;
  assign bus.timer_reset  = t_reset_q;
  assign bus.timer_inc_en = ~mode_q;
  assign bus.mode         = mode_q;
  assign bus.disp_minutes = disp_min_q;
  assign bus.disp_seconds = disp_sec_q;
  assign bus.blink        = blink_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: the model tracks the stopwatch as a plain tick
// total and derives MM:SS by division; MAX_MIN is lowered to keep overflow short.
module tb_stopwatch_ctrl;
  localparam int MS    = 4;
  localparam int MAXM  = 2;
  localparam int LIMIT = (MAXM * 60 + 60) * MS;

  localparam logic [4:0] B_START = 5'b00001;
  localparam logic [4:0] B_STOP  = 5'b00010;
  localparam logic [4:0] B_SOFT  = 5'b00100;
  localparam logic [4:0] B_MODE  = 5'b01000;
  localparam logic [4:0] B_LAP   = 5'b10000;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] tmin, tsec;
  logic tblink;

  stopwatch_ctrl_if bus();
  assign bus.timer_minutes = tmin;
  assign bus.timer_seconds = tsec;
  assign bus.timer_blink   = tblink;

  stopwatch_ctrl #(.MS_PER_SEC(MS), .MAX_MIN(MAXM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_ts = 0, n_tp = 0, n_tr = 0;

  always @(posedge clk) begin
    if (bus.timer_start) n_ts <= n_ts + 1;
    if (bus.timer_stop)  n_tp <= n_tp + 1;
    if (bus.timer_reset) n_tr <= n_tr + 1;
  end

  typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE, M_OVF} mst_e;
  mst_e m_st;
  int   m_total, m_lap;
  bit   m_mode;

  logic [5:0] em, es;
  logic eb;
  int as, ap, ar, xs, xp, xr;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_total = 0; m_lap = 0; m_mode = 1'b0;
  endtask

  task automatic model_exp(output logic [5:0] mm, output logic [5:0] ss, output logic bb);
    int v, s;
    if (!m_mode) begin
      mm = tmin; ss = tsec; bb = tblink;
    end else begin
      v  = (m_st == M_LAP) ? m_lap : m_total;
      s  = v / MS;
      mm = 6'(s / 60);
      ss = 6'(s % 60);
      bb = (m_st == M_PAUSE) || (m_st == M_OVF);
    end
  endtask

  // Holds a button combination, releases it, and updates the model.
  task automatic press(input logic [4:0] m, input int hold,
                       output int a_s, output int a_p, output int a_r,
                       output int x_s, output int x_p, output int x_r);
    int b_s, b_p, b_r;
    b_s = n_ts; b_p = n_tp; b_r = n_tr;
    {bus.lap_btn, bus.mode_btn, bus.softrst, bus.stop, bus.start} = m;
    cyc(hold);
    {bus.lap_btn, bus.mode_btn, bus.softrst, bus.stop, bus.start} = '0;
    cyc(3);
    a_s = n_ts - b_s; a_p = n_tp - b_p; a_r = n_tr - b_r;
    x_s = 0; x_p = 0; x_r = 0;
    if (!m_mode) begin
      x_s = int'(m[0]); x_p = int'(m[1]); x_r = int'(m[2]);
    end else if (m[2]) begin
      m_st = M_IDLE; m_total = 0; m_lap = 0;
    end else begin
      case (m_st)
        M_IDLE:  if (m[0]) m_st = M_RUN;
        M_RUN:   if (m[1]) m_st = M_PAUSE;
                 else if (m[4]) begin m_st = M_LAP; m_lap = m_total; end
        M_LAP:   if (m[1]) m_st = M_PAUSE; else if (m[4]) m_st = M_RUN;
        M_PAUSE: if (m[0]) m_st = M_RUN;
        default: ;
      endcase
    end
    if (m[3]) m_mode = !m_mode;
  endtask

  task automatic rises(input int n);
    for (int i = 0; i < n; i++) begin
      bus.clk1k = 1'b1;
      cyc($urandom_range(1, 3));
      bus.clk1k = 1'b0;
      cyc($urandom_range(1, 3));
      if (m_st == M_RUN || m_st == M_LAP) begin
        if (m_total == LIMIT - 1) m_st = M_OVF;
        else m_total++;
      end
    end
    cyc(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.clk1k = 1'b0;
    {bus.lap_btn, bus.mode_btn, bus.softrst, bus.stop, bus.start} = '0;
    tmin = 6'd17; tsec = 6'd42; tblink = 1'b1;
    cyc(3);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== 13'd0) begin
      failures++;
      $display("FAIL reset_disp got=%0d:%0d b=%0d want=0:0 b=0", bus.disp_minutes, bus.disp_seconds, bus.blink);
    end
    checks++;
    if ({bus.mode, bus.timer_inc_en} !== 2'b01) begin
      failures++;
      $display("FAIL reset_mode got mode=%0d inc_en=%0d want 0/1", bus.mode, bus.timer_inc_en);
    end
    checks++;
    if ({bus.timer_start, bus.timer_stop, bus.timer_reset} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses got=%b want=000", {bus.timer_start, bus.timer_stop, bus.timer_reset});
    end
    rst_n = 1'b0;
    model_reset();
    cyc(2);
    model_exp(em, es, eb);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== {em, es, eb}) begin
      failures++;
      $display("FAIL reset_timer_view got=%0d:%0d b=%0d want=%0d:%0d b=%0d", bus.disp_minutes, bus.disp_seconds, bus.blink, em, es, eb);
    end
  endtask

  task automatic test_timer_route();
    press(B_START, 10, as, ap, ar, xs, xp, xr);
    checks++;
    if (as !== 1 || ap !== 0 || ar !== 0) begin
      failures++;
      $display("FAIL timer_start_pulse got=%0d/%0d/%0d want=1/0/0", as, ap, ar);
    end
    press(B_STOP, $urandom_range(1, 6), as, ap, ar, xs, xp, xr);
    press(B_SOFT, $urandom_range(1, 6), as, ap, ar, xs, xp, xr);
    checks++;
    if (as !== 0 || ap !== 0 || ar !== 1) begin
      failures++;
      $display("FAIL timer_reset_pulse got=%0d/%0d/%0d want=0/0/1", as, ap, ar);
    end
    press(B_LAP, 2, as, ap, ar, xs, xp, xr);
    tmin = 6'($urandom_range(0, 59)); tsec = 6'($urandom_range(0, 59)); tblink = 1'($urandom_range(0, 1));
    rises(8);
    model_exp(em, es, eb);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== {em, es, eb}) begin
      failures++;
      $display("FAIL timer_view got=%0d:%0d b=%0d want=%0d:%0d b=%0d", bus.disp_minutes, bus.disp_seconds, bus.blink, em, es, eb);
    end
  endtask

  task automatic test_run_pause();
    press(B_MODE, 3, as, ap, ar, xs, xp, xr);
    checks++;
    if ({bus.mode, bus.timer_inc_en, bus.disp_minutes, bus.disp_seconds, bus.blink} !== {1'b1, 1'b0, 13'd0}) begin
      failures++;
      $display("FAIL sw_enter got mode=%0d inc=%0d %0d:%0d want 1/0 0:0 (stopwatch should be idle)", bus.mode, bus.timer_inc_en, bus.disp_minutes, bus.disp_seconds);
    end
    press(B_START, 4, as, ap, ar, xs, xp, xr);
    checks++;
    if (as !== 0) begin
      failures++;
      $display("FAIL sw_start_no_timer got=%0d want=0", as);
    end
    rises(8);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== {6'd0, 6'd2, 1'b0}) begin
      failures++;
      $display("FAIL run_count got=%0d:%0d b=%0d want=0:2 b=0", bus.disp_minutes, bus.disp_seconds, bus.blink);
    end
    press(B_STOP, 2, as, ap, ar, xs, xp, xr);
    rises(8);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== {6'd0, 6'd2, 1'b1}) begin
      failures++;
      $display("FAIL pause_hold got=%0d:%0d b=%0d want=0:2 b=1", bus.disp_minutes, bus.disp_seconds, bus.blink);
    end
  endtask

  task automatic test_lap();
    press(B_SOFT, 2, as, ap, ar, xs, xp, xr);
    press(B_START, 2, as, ap, ar, xs, xp, xr);
    rises(4);
    press(B_LAP, 3, as, ap, ar, xs, xp, xr);
    rises(8);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== {6'd0, 6'd1, 1'b0}) begin
      failures++;
      $display("FAIL lap_frozen got=%0d:%0d b=%0d want=0:1 b=0", bus.disp_minutes, bus.disp_seconds, bus.blink);
    end
    press(B_LAP, 3, as, ap, ar, xs, xp, xr);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds} !== {6'd0, 6'd3}) begin
      failures++;
      $display("FAIL lap_release got=%0d:%0d want=0:3", bus.disp_minutes, bus.disp_seconds);
    end
  endtask

  task automatic test_simultaneous();
    press(B_SOFT, 2, as, ap, ar, xs, xp, xr);
    press(B_START, 2, as, ap, ar, xs, xp, xr);
    rises(4);
    press(B_STOP | B_LAP, 2, as, ap, ar, xs, xp, xr);
    press(B_START, 2, as, ap, ar, xs, xp, xr);
    rises(4);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== {6'd0, 6'd2, 1'b0}) begin
      failures++;
      $display("FAIL stop_beats_lap got=%0d:%0d b=%0d want=0:2 b=0", bus.disp_minutes, bus.disp_seconds, bus.blink);
    end
    press(B_SOFT | B_START, 2, as, ap, ar, xs, xp, xr);
    rises(4);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== 13'd0) begin
      failures++;
      $display("FAIL soft_beats_start got=%0d:%0d b=%0d want=0:0 b=0", bus.disp_minutes, bus.disp_seconds, bus.blink);
    end
    press(B_MODE | B_START, 2, as, ap, ar, xs, xp, xr);
    checks++;
    if (bus.mode !== 1'b0 || as !== 0) begin
      failures++;
      $display("FAIL mode_start_sw got mode=%0d tstart=%0d want 0/0", bus.mode, as);
    end
    press(B_MODE | B_START, 2, as, ap, ar, xs, xp, xr);
    checks++;
    if (bus.mode !== 1'b1 || as !== 1) begin
      failures++;
      $display("FAIL mode_start_timer got mode=%0d tstart=%0d want 1/1", bus.mode, as);
    end
    rises(4);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds} !== {6'd0, 6'd1}) begin
      failures++;
      $display("FAIL background_run got=%0d:%0d want=0:1", bus.disp_minutes, bus.disp_seconds);
    end
  endtask

  task automatic test_overflow();
    press(B_SOFT, 2, as, ap, ar, xs, xp, xr);
    press(B_START, 2, as, ap, ar, xs, xp, xr);
    rises(LIMIT - 1);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== {6'(MAXM), 6'd59, 1'b0}) begin
      failures++;
      $display("FAIL ovf_edge got=%0d:%0d b=%0d want=%0d:59 b=0", bus.disp_minutes, bus.disp_seconds, bus.blink, MAXM);
    end
    rises(4);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== {6'(MAXM), 6'd59, 1'b1}) begin
      failures++;
      $display("FAIL ovf_hold got=%0d:%0d b=%0d want=%0d:59 b=1", bus.disp_minutes, bus.disp_seconds, bus.blink, MAXM);
    end
    press(B_START, 2, as, ap, ar, xs, xp, xr);
    rises(4);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== {6'(MAXM), 6'd59, 1'b1}) begin
      failures++;
      $display("FAIL ovf_start_ignored got=%0d:%0d b=%0d want=%0d:59 b=1", bus.disp_minutes, bus.disp_seconds, bus.blink, MAXM);
    end
    press(B_SOFT, 2, as, ap, ar, xs, xp, xr);
    checks++;
    if ({bus.disp_minutes, bus.disp_seconds, bus.blink} !== 13'd0) begin
      failures++;
      $display("FAIL ovf_softrst got=%0d:%0d b=%0d want=0:0 b=0", bus.disp_minutes, bus.disp_seconds, bus.blink);
    end
  endtask

  task automatic test_random();
    logic [4:0] ops [5];
    logic [4:0] m;
    ops = '{B_START, B_STOP, B_SOFT, B_LAP, B_MODE};
    for (int it = 0; it < 40; it++) begin
      tmin = 6'($urandom_range(0, 59)); tsec = 6'($urandom_range(0, 59)); tblink = 1'($urandom_range(0, 1));
      m = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) m = m | ops[$urandom_range(0, 4)];
      press(m, $urandom_range(1, 5), as, ap, ar, xs, xp, xr);
      checks++;
      if (as !== xs || ap !== xp || ar !== xr) begin
        failures++;
        $display("FAIL rnd_pulses it=%0d btn=%b got=%0d/%0d/%0d want=%0d/%0d/%0d", it, m, as, ap, ar, xs, xp, xr);
      end
      rises($urandom_range(0, 9));
      model_exp(em, es, eb);
      checks++;
      if ({bus.mode, bus.timer_inc_en, bus.disp_minutes, bus.disp_seconds, bus.blink} !== {m_mode, !m_mode, em, es, eb}) begin
        failures++;
        $display("FAIL rnd_view it=%0d got m=%0d %0d:%0d b=%0d want m=%0d %0d:%0d b=%0d", it, bus.mode, bus.disp_minutes, bus.disp_seconds, bus.blink, m_mode, em, es, eb);
      end
    end
  endtask

  task automatic test_async_reset();
    if (!m_mode) press(B_MODE, 2, as, ap, ar, xs, xp, xr);
    press(B_SOFT, 2, as, ap, ar, xs, xp, xr);
    press(B_START, 2, as, ap, ar, xs, xp, xr);
    rises(6);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.mode, bus.timer_inc_en, bus.disp_minutes, bus.disp_seconds, bus.blink} !== {1'b0, 1'b1, 13'd0}) begin
      failures++;
      $display("FAIL async_reset got m=%0d inc=%0d %0d:%0d b=%0d want 0/1 0:0 b=0", bus.mode, bus.timer_inc_en, bus.disp_minutes, bus.disp_seconds, bus.blink);
    end
    cyc(2);
    rst_n = 1'b0;
    model_reset();
    cyc(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_timer_route();
    test_run_pause();
    test_lap();
    test_simultaneous();
    test_overflow();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
